cache_axi_arbiter: RTL and testbench

- Sits directly upstream of the AXI bridge and arbitrates ICache and DCache miss/uncached requests onto the bridge's single request port (req/ad/wword/wword_en/cached).
- Returns the bridge's result (rword, task_finish) to the winning requester only.
- At most one transaction is in flight at a time.
- ICache issues loads only; DCache issues loads and stores.

---
 rtl/cache_axi_arbiter.sv | 153 +++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: merges ICache and DCache miss/uncached requests onto the
// single request port of the AXI bridge. One transaction is in flight at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the winner on contention
// instead of fixed DCache priority with a starvation guard.
module cache_axi_arbiter #(
  parameter int STARVE_LIMIT  = 4,
  parameter int AXI_REQ_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  // ICache side (loads only)
  input  logic                     i_req_valid,
  output logic                     i_req_ready,
  input  logic [31:0]              i_addr,
  input  logic                     i_cached,
  output logic                     i_resp_valid,
  output logic [31:0]              i_rdata,
  // DCache side (loads and stores)
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic                     d_we,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  input  logic [3:0]               d_wstrb,
  input  logic                     d_cached,
  output logic                     d_resp_valid,
  output logic [31:0]              d_rdata,
  // AXI bridge side
  output logic [AXI_REQ_WIDTH-1:0] req,
  output logic [31:0]              ad,
  output logic [31:0]              wword,
  output logic [3:0]               wword_en,
  output logic                     cached,
  input  logic                     ready_to_pipline,
  input  logic                     task_finish,
  input  logic [31:0]              rword
);

  localparam logic [AXI_REQ_WIDTH-1:0] REQ_TO_AXI_NONE = AXI_REQ_WIDTH'(0);
  localparam logic [AXI_REQ_WIDTH-1:0] LOAD_WORD       = AXI_REQ_WIDTH'(1);
  localparam logic [AXI_REQ_WIDTH-1:0] WRITE_WORD      = AXI_REQ_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_owner;      // 0 = ICache, 1 = DCache
  logic        r_we;
  logic [31:0] r_ad, r_wword, r_i_rdata, r_d_rdata;
  logic [3:0]  r_wstrb;
  logic        r_cached;
  logic        w_grant, w_win_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;        // 1 = DCache won last; reset to D so I wins first contention

  // Winner selection: on contention, whoever was not granted last
  always_comb begin
    w_win_d = d_req_valid && (!i_req_valid || !r_last_grant);
  end

  // Remember the most recent winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last_grant <= 1'b1;
    else if (w_grant) r_last_grant <= w_win_d;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  // Winner selection: DCache first unless ICache has been passed over LIMIT times
  always_comb begin
    w_win_d = d_req_valid && (!i_req_valid || (r_starve_cnt != LIMIT));
  end

  // Count consecutive DCache grants made while ICache was waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      if (w_win_d && i_req_valid)
        r_starve_cnt <= (r_starve_cnt == LIMIT) ? r_starve_cnt : r_starve_cnt + 4'd1;
      else
        r_starve_cnt <= '0;
    end
  end
`endif

  // Grant only from IDLE with an idle bridge and somebody asking
  always_comb begin
    w_grant = (r_state == IDLE) && ready_to_pipline && (i_req_valid || d_req_valid);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; task_finish outside WAIT is ignored
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (task_finish) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Holding registers latched at grant; read data captured on task_finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_ad      <= '0;
      r_wword   <= '0;
      r_wstrb   <= '0;
      r_cached  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_win_d;
        r_we     <= w_win_d & d_we;
        r_ad     <= w_win_d ? d_addr   : i_addr;
        r_wword  <= w_win_d ? d_wdata  : '0;
        r_wstrb  <= w_win_d ? d_wstrb  : '0;
        r_cached <= w_win_d ? d_cached : i_cached;
      end
      if (r_state == WAIT && task_finish) begin
        if (r_owner) r_d_rdata <= rword;
        else         r_i_rdata <= rword;
      end
    end
  end

  // Handshake pulses decode from state so reset clears them immediately
  assign i_req_ready  = (r_state == ISSUE) && !r_owner;
  assign d_req_ready  = (r_state == ISSUE) &&  r_owner;
  assign i_resp_valid = (r_state == RESP)  && !r_owner;
  assign d_resp_valid = (r_state == RESP)  &&  r_owner;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;

  // Bridge port: request is a one-cycle strobe, fields held until next grant
  assign req      = (r_state != ISSUE) ? REQ_TO_AXI_NONE : (r_we ? WRITE_WORD : LOAD_WORD);
  assign ad       = r_ad;
  assign wword    = r_wword;
  assign wword_en = r_wstrb;
  assign cached   = r_cached;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter: stimulus pushes expected grants,
// bridge requests and responses; a monitor and a bridge model pop and compare.
module tb_cache_axi_arbiter;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, WRITE = 2'd2;

  logic        clk = 0, rst = 1;
  logic        i_req_valid = 0, i_cached = 0;
  logic [31:0] i_addr = 0;
  logic        d_req_valid = 0, d_we = 0, d_cached = 0;
  logic [31:0] d_addr = 0, d_wdata = 0;
  logic [3:0]  d_wstrb = 0;
  logic        ready_to_pipline = 1, task_finish = 0;
  logic [31:0] rword = 0;
  logic        i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, cached;
  logic [31:0] i_rdata, d_rdata, ad, wword;
  logic [3:0]  wword_en;
  logic [1:0]  req;

  cache_axi_arbiter #(.STARVE_LIMIT(4), .AXI_REQ_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_cached(i_cached), .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_cached(d_cached),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
    .req(req), .ad(ad), .wword(wword), .wword_en(wword_en), .cached(cached),
    .ready_to_pipline(ready_to_pipline), .task_finish(task_finish), .rword(rword)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          cch;
    logic [31:0] rdata;
  } txn_t;

  txn_t gq[$], bq[$], rq[$];
  int checks = 0, errors = 0;
  int cyc = 0, tf_cyc = 0, br_lat = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void expect_txn(bit is_d, bit we, logic [31:0] a, logic [31:0] wd,
                                     logic [3:0] st, bit c, logic [31:0] rw, bit resp);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = a; t.wdata = wd; t.strb = st; t.cch = c; t.rdata = rw;
    gq.push_back(t);
    bq.push_back(t);
    if (resp) rq.push_back(t);
  endfunction

  // Monitor: grant pulses and response pulses
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (i_req_ready || d_req_ready) begin
      chk("grant_excl", {31'd0, i_req_ready & d_req_ready}, 0);
      if (gq.size() == 0) chk("grant_unexpected", 1, 0);
      else begin
        t = gq.pop_front();
        chk("grant_port", {31'd0, d_req_ready}, {31'd0, t.is_d});
      end
    end
    if (i_resp_valid || d_resp_valid) begin
      chk("resp_excl", {31'd0, i_resp_valid & d_resp_valid}, 0);
      if (rq.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        t = rq.pop_front();
        chk("resp_port", {31'd0, d_resp_valid}, {31'd0, t.is_d});
        chk("resp_lat", cyc - tf_cyc, 1);
        if (!t.we) chk("resp_data", t.is_d ? d_rdata : i_rdata, t.rdata);
      end
    end
  end

  // Bridge model: accepts a request, finishes br_lat cycles later, aborts on reset
  initial forever begin
    txn_t t;
    logic [31:0] h_ad, h_wd;
    logic [3:0]  h_st;
    logic        h_c;
    bit          aborted, stable;
    @(negedge clk);
    if (!rst && req != NONE) begin
      if (bq.size() == 0) chk("bridge_unexpected", 1, 0);
      else begin
        t = bq.pop_front();
        chk("req_type", {30'd0, req}, t.we ? {30'd0, WRITE} : {30'd0, LOAD});
        chk("req_ad", ad, t.addr);
        chk("req_cached", {31'd0, cached}, {31'd0, t.cch});
        if (t.we) begin
          chk("req_wword", wword, t.wdata);
          chk("req_wstrb", {28'd0, wword_en}, {28'd0, t.strb});
        end
        h_ad = ad; h_wd = wword; h_st = wword_en; h_c = cached;
        ready_to_pipline = 0;
        aborted = 0; stable = 1;
        for (int n = 1; n <= br_lat; n++) begin
          @(negedge clk);
          if (rst) begin aborted = 1; break; end
          if (n == 1) chk("req_one_cycle", {30'd0, req}, {30'd0, NONE});
          if (ad !== h_ad || wword !== h_wd || wword_en !== h_st || cached !== h_c) stable = 0;
        end
        if (!aborted) begin
          task_finish = 1; rword = t.rdata; tf_cyc = cyc;
          @(negedge clk);
          if (ad !== h_ad || wword !== h_wd || wword_en !== h_st || cached !== h_c) stable = 0;
          chk("fields_hold", {31'd0, stable}, 1);
        end
        task_finish = 0; rword = 0;
        ready_to_pipline = 1;
      end
    end
  end

  task automatic do_i(input logic [31:0] a, input bit c, output int n);
    i_addr = a; i_cached = c; i_req_valid = 1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (i_req_ready) break;
    end
    if (n == 200) chk("i_grant_timeout", 1, 0);
    @(posedge clk); #1;
    i_req_valid = 0;
  endtask

  task automatic do_d(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit c, output int n);
    d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st; d_cached = c; d_req_valid = 1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (d_req_ready) break;
    end
    if (n == 200) chk("d_grant_timeout", 1, 0);
    @(posedge clk); #1;
    d_req_valid = 0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (gq.size() == 0 && bq.size() == 0 && rq.size() == 0 && ready_to_pipline) break;
    end
    if (k == 500) chk("drain_timeout", 1, 0);
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ord[10];
    int ki, kd;
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_req", {30'd0, req}, {30'd0, NONE});
    chk("rst_ad", ad, 0);
    chk("rst_wword", wword, 0);
    chk("rst_wword_en", {28'd0, wword_en}, 0);
    chk("rst_handshake", {28'd0, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    rst = 0;
    @(posedge clk); #1;

    // ICache load, grant one cycle after the request is seen
    expect_txn(0, 0, 32'h1C00_0000, 0, 0, 1, 32'hDEAD_BEEF, 1);
    do_i(32'h1C00_0000, 1, n);
    chk("i_grant_lat", n, 1);
    drain();

    // DCache store
    expect_txn(1, 1, 32'h8000_1000, 32'h1234_5678, 4'hF, 0, 32'h0, 1);
    do_d(1, 32'h8000_1000, 32'h1234_5678, 4'hF, 0, n);
    drain();

    // Simultaneous I and D loads
`ifdef ARB_ROUND_ROBIN_EN
    expect_txn(0, 0, 32'h1C00_0040, 0, 0, 1, 32'h1111_0000, 1);
    expect_txn(1, 0, 32'h8000_2000, 0, 0, 0, 32'h2222_0000, 1);
`else
    expect_txn(1, 0, 32'h8000_2000, 0, 0, 0, 32'h2222_0000, 1);
    expect_txn(0, 0, 32'h1C00_0040, 0, 0, 1, 32'h1111_0000, 1);
`endif
    fork
      begin int m; do_i(32'h1C00_0040, 1, m); end
      begin int m; do_d(0, 32'h8000_2000, 0, 0, 0, m); end
    join
    drain();

    // Both continuously valid: 2 ICache loads, 8 DCache loads (1 = D in grant order)
`ifdef ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
`else
    ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    ki = 0; kd = 0;
    for (int g = 0; g < 10; g++) begin
      if (ord[g]) begin
        expect_txn(1, 0, 32'h8000_3000 + 32'(4*kd), 0, 0, 1, 32'hB000_0000 + 32'(kd), 1);
        kd++;
      end else begin
        expect_txn(0, 0, 32'h1C00_0100 + 32'(4*ki), 0, 0, 1, 32'hA000_0000 + 32'(ki), 1);
        ki++;
      end
    end
    fork
      begin for (int k = 0; k < 2; k++) begin int m; do_i(32'h1C00_0100 + 32'(4*k), 1, m); end end
      begin for (int k = 0; k < 8; k++) begin int m; do_d(0, 32'h8000_3000 + 32'(4*k), 0, 0, 1, m); end end
    join
    drain();

    // Reset while waiting on the bridge: request dropped, no response
    br_lat = 20;
    expect_txn(1, 0, 32'h8000_4000, 0, 0, 1, 32'h3333_3333, 0);
    do_d(0, 32'h8000_4000, 0, 0, 1, n);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("midrst_req", {30'd0, req}, {30'd0, NONE});
    chk("midrst_ad", ad, 0);
    chk("midrst_cached", {31'd0, cached}, 0);
    chk("midrst_handshake", {28'd0, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid}, 0);
    chk("midrst_rdata", i_rdata | d_rdata, 0);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    br_lat = 3;
    @(posedge clk); #1;
    expect_txn(1, 0, 32'h8000_5000, 0, 0, 0, 32'hCAFE_F00D, 1);
    do_d(0, 32'h8000_5000, 0, 0, 0, n);
    drain();

    chk("gq_empty", gq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
